// File: rtl/pipe_latch_elastic.sv
// Elastic inter-stage pipeline latch: main entry plus one skid entry, registered upstream stall,
// bubble collapse, flush and a saturating stall-cycle counter.
module pipe_latch_elastic #(
    parameter int WIDTH      = 270,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_v,
    output logic              o_stall_up,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_v,
    input  logic              i_stall_dn,
    input  logic              i_flush,
    output logic [PERF_W-1:0] o_stall_cnt
);

    // Encoding is {main_v, skid_v}, so the valids and the upstream stall come straight off flops.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_FULL  = 2'b11
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_main_data;
    logic [WIDTH-1:0]   r_skid_data;
    logic [PERF_W-1:0]  r_stall_cnt;

    logic w_main_v;
    logic w_skid_v;
    logic w_accept;
    logic w_drain;

    assign w_main_v = r_state[1];
    assign w_skid_v = r_state[0];
    assign w_accept = i_v & ~w_skid_v;
    assign w_drain  = w_main_v & ~i_stall_dn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_main_data <= '0;
            r_skid_data <= '0;
        end else if (i_flush) begin
            r_state <= S_EMPTY;
            if (CLEAR_DATA) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_main_data <= i_data;
                        r_state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_drain && w_accept) begin
                        r_main_data <= i_data;
                    end else if (w_drain) begin
                        r_state <= S_EMPTY;
                    end else if (w_accept) begin
                        r_skid_data <= i_data;
                        r_state     <= S_FULL;
                    end
                end
                S_FULL: begin
                    // Upstream was stalled this cycle, so only the skid entry moves forward.
                    if (w_drain) begin
                        r_main_data <= r_skid_data;
                        r_state     <= S_ONE;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    // Counts regardless of flush: a stalled valid in the flush cycle still cost a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_main_v && i_stall_dn && (r_stall_cnt != {PERF_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign o_v         = w_main_v;
    assign o_stall_up  = w_skid_v;
    assign o_data      = r_main_data;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_latch_elastic.sv
// Directed bench for pipe_latch_elastic: one instance keeps stale data on flush with a wide
// counter, the other clears data on flush and has a 2-bit counter.
module tb_pipe_latch_elastic;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    logic [W-1:0]  d1_data = '0;
    logic          d1_v = 1'b0, d1_stall_dn = 1'b0, d1_flush = 1'b0;
    logic          o1_stall_up, o1_v;
    logic [W-1:0]  o1_data;
    logic [15:0]   o1_cnt;

    logic [W-1:0]  d2_data = '0;
    logic          d2_v = 1'b0, d2_stall_dn = 1'b0, d2_flush = 1'b0;
    logic          o2_stall_up, o2_v;
    logic [W-1:0]  o2_data;
    logic [1:0]    o2_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_latch_elastic #(.WIDTH(W), .CLEAR_DATA(1'b0), .PERF_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .i_data(d1_data), .i_v(d1_v), .o_stall_up(o1_stall_up),
        .o_data(o1_data), .o_v(o1_v), .i_stall_dn(d1_stall_dn), .i_flush(d1_flush),
        .o_stall_cnt(o1_cnt)
    );

    pipe_latch_elastic #(.WIDTH(W), .CLEAR_DATA(1'b1), .PERF_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .i_data(d2_data), .i_v(d2_v), .o_stall_up(o2_stall_up),
        .o_data(o2_data), .o_v(o2_v), .i_stall_dn(d2_stall_dn), .i_flush(d2_flush),
        .o_stall_cnt(o2_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv1(input logic v, input logic [W-1:0] d, input logic sd, input logic fl);
        d1_v = v; d1_data = d; d1_stall_dn = sd; d1_flush = fl;
    endtask

    task automatic drv2(input logic v, input logic [W-1:0] d, input logic sd, input logic fl);
        d2_v = v; d2_data = d; d2_stall_dn = sd; d2_flush = fl;
    endtask

    initial begin
        // reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_o_v", 32'(o1_v), 32'd0);
        chk("rst_stall_up", 32'(o1_stall_up), 32'd0);
        chk("rst_o_data", 32'(o1_data), 32'h0);
        chk("rst_cnt", 32'(o1_cnt), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("idle_o_v", 32'(o1_v), 32'd0);

        // full-throughput stream, one cycle latency
        for (int k = 1; k <= 8; k++) begin
            drv1(1'b1, W'(k), 1'b0, 1'b0);
            step();
            chk($sformatf("stream_data_%0d", k), 32'(o1_data), 32'(k));
            chk($sformatf("stream_v_%0d", k), 32'(o1_v), 32'd1);
            chk($sformatf("stream_stall_up_%0d", k), 32'(o1_stall_up), 32'd0);
        end
        drv1(1'b0, '0, 1'b0, 1'b0);
        step();
        chk("stream_drained", 32'(o1_v), 32'd0);

        // downstream stall fills skid, then releases in order
        drv1(1'b1, 16'h000A, 1'b1, 1'b0);
        step();
        chk("stall_c1_data", 32'(o1_data), 32'hA);
        chk("stall_c1_up", 32'(o1_stall_up), 32'd0);
        drv1(1'b1, 16'h000B, 1'b1, 1'b0);
        step();
        chk("stall_c2_data", 32'(o1_data), 32'hA);
        chk("stall_c2_up", 32'(o1_stall_up), 32'd1);
        chk("stall_c2_cnt", 32'(o1_cnt), 32'd1);
        drv1(1'b1, 16'h000C, 1'b1, 1'b0);
        step();
        chk("stall_c3_data", 32'(o1_data), 32'hA);
        chk("stall_c3_up", 32'(o1_stall_up), 32'd1);
        chk("stall_c3_cnt", 32'(o1_cnt), 32'd2);
        drv1(1'b1, 16'h000C, 1'b0, 1'b0);
        step();
        chk("rel_b_data", 32'(o1_data), 32'hB);
        chk("rel_b_up", 32'(o1_stall_up), 32'd0);
        step();
        chk("rel_c_data", 32'(o1_data), 32'hC);
        chk("rel_c_v", 32'(o1_v), 32'd1);
        drv1(1'b0, '0, 1'b0, 1'b0);
        step();
        chk("rel_empty", 32'(o1_v), 32'd0);
        chk("rel_cnt", 32'(o1_cnt), 32'd2);

        // bubble collapse: stalled downstream does not block an empty latch
        drv1(1'b1, 16'h0055, 1'b1, 1'b0);
        step();
        chk("bubble_v", 32'(o1_v), 32'd1);
        chk("bubble_data", 32'(o1_data), 32'h55);
        chk("bubble_cnt", 32'(o1_cnt), 32'd2);

        // flush from FULL, stale data kept
        drv1(1'b1, 16'h0066, 1'b1, 1'b0);
        step();
        chk("full1_up", 32'(o1_stall_up), 32'd1);
        chk("full1_cnt", 32'(o1_cnt), 32'd3);
        drv1(1'b1, 16'h0077, 1'b1, 1'b1);
        step();
        chk("flush1_v", 32'(o1_v), 32'd0);
        chk("flush1_up", 32'(o1_stall_up), 32'd0);
        chk("flush1_stale", 32'(o1_data), 32'h55);
        chk("flush1_cnt", 32'(o1_cnt), 32'd4);
        drv1(1'b0, '0, 1'b0, 1'b0);
        step();
        chk("post_flush1_v", 32'(o1_v), 32'd0);
        drv1(1'b1, 16'h0088, 1'b0, 1'b0);
        step();
        chk("post_flush1_data", 32'(o1_data), 32'h88);
        drv1(1'b0, '0, 1'b0, 1'b0);
        step();
        chk("post_flush1_empty", 32'(o1_v), 32'd0);

        // flush from FULL on the clearing instance
        drv2(1'b1, 16'h0011, 1'b1, 1'b0);
        step();
        chk("d2_one_v", 32'(o2_v), 32'd1);
        chk("d2_one_cnt", 32'(o2_cnt), 32'd0);
        drv2(1'b1, 16'h0022, 1'b1, 1'b0);
        step();
        chk("d2_full_up", 32'(o2_stall_up), 32'd1);
        chk("d2_full_cnt", 32'(o2_cnt), 32'd1);
        drv2(1'b1, 16'h0077, 1'b1, 1'b1);
        step();
        chk("flush2_v", 32'(o2_v), 32'd0);
        chk("flush2_up", 32'(o2_stall_up), 32'd0);
        chk("flush2_data", 32'(o2_data), 32'h0);
        chk("flush2_cnt", 32'(o2_cnt), 32'd2);
        drv2(1'b0, '0, 1'b0, 1'b0);
        step();
        chk("post_flush2_v", 32'(o2_v), 32'd0);
        chk("post_flush2_data", 32'(o2_data), 32'h0);

        // async reset clears the counter
        #3 rst = 1'b1;
        #1;
        chk("rst2_cnt", 32'(o2_cnt), 32'd0);
        chk("rst2_cnt1", 32'(o1_cnt), 32'd0);
        step();
        rst = 1'b0;

        // 2-bit counter saturation
        drv2(1'b1, 16'h0033, 1'b1, 1'b0);
        step();
        chk("sat_load_v", 32'(o2_v), 32'd1);
        drv2(1'b0, '0, 1'b1, 1'b0);
        begin
            logic [1:0] sat_exp [6];
            sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
            for (int k = 0; k < 6; k++) begin
                step();
                chk($sformatf("sat_cnt_%0d", k), 32'(o2_cnt), 32'(sat_exp[k]));
            end
        end
        chk("sat_hold_data", 32'(o2_data), 32'h33);

        // mid-stream async reset drops everything
        #3 rst = 1'b1;
        #1;
        chk("midrst_v", 32'(o2_v), 32'd0);
        chk("midrst_data", 32'(o2_data), 32'h0);
        chk("midrst_cnt", 32'(o2_cnt), 32'd0);
        step();
        rst = 1'b0;
        drv2(1'b0, '0, 1'b0, 1'b0);
        step();
        chk("midrst_after_v", 32'(o2_v), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout compared=%0d expected=finish", n_cmp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule
